// File: rtl/seq_calc_core.sv
// seq_calc_core: sequential signed calculator.
// Logic ops, ADD, SUB and NEG finish on the edge that accepts them. MUL (shift-add)
// and DIV (restoring) work on operand magnitudes one bit per edge and apply the
// sign at the end. Overflowed results either wrap or clamp, selected by SATURATE.
module seq_calc_core #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             chain,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done
);

  // Exact results are held in PW bits, enough for a full signed product.
  localparam int PW = 2 * WIDTH + 1;
  localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);
  localparam logic signed [PW-1:0] MAX_X = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_X = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_R = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_R = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, FINISH} state_t;

  state_t             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;       // MUL partial product
  logic [2*WIDTH-1:0] mcand_q, mcand_d;   // MUL shifted multiplicand / DIV divisor (low half)
  logic [WIDTH-1:0]   mplier_q, mplier_d; // MUL multiplier / DIV dividend, both shifted
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]     opb;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH:0]       rem_sh;
  logic                 rem_ge;
  logic [WIDTH-1:0]     quo_step;
  logic                 fin;
  logic signed [PW-1:0] exact_x;
  logic signed [PW-1:0] mag_x;
  logic [WIDTH:0]       fin_x;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? WIDTH'(-x) : x;
  endfunction

  function automatic logic signed [PW-1:0] sext(input logic [WIDTH-1:0] x);
    return {{(WIDTH+1){x[WIDTH-1]}}, x};
  endfunction

  // Returns {overflow, result} for an exact signed value.
  function automatic logic [WIDTH:0] finalize(input logic signed [PW-1:0] x);
    logic ovf;
    logic [WIDTH-1:0] r;
    ovf = (x > MAX_X) || (x < MIN_X);
    r = x[WIDTH-1:0];
    if (ovf && SATURATE) r = x[PW-1] ? MIN_R : MAX_R;
    return {ovf, r};
  endfunction

  // Next-state, datapath step and completion logic; everything holds when enable=0.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    neg_d    = neg_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    done_d   = done_q;
    fin      = 1'b0;
    exact_x  = '0;
    mag_x    = '0;
    fin_x    = '0;
    opb      = chain ? result_q : b;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    rem_sh   = {rem_q, mplier_q[WIDTH-1]};
    rem_ge   = rem_sh >= {1'b0, mcand_q[WIDTH-1:0]};
    quo_step = (quo_q << 1) | {{(WIDTH-1){1'b0}}, rem_ge};
    if (enable) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              3'd0: begin fin = 1'b1; exact_x = sext(a) + sext(opb); end
              3'd1: begin fin = 1'b1; exact_x = sext(a) - sext(opb); end
              3'd2: begin fin = 1'b1; exact_x = sext(a & opb); end
              3'd3: begin fin = 1'b1; exact_x = sext(a | opb); end
              3'd4: begin fin = 1'b1; exact_x = sext(a ^ opb); end
              3'd5: begin fin = 1'b1; exact_x = -sext(a); end
              3'd6: begin
                neg_d    = a[WIDTH-1] ^ opb[WIDTH-1];
                mcand_d  = {{WIDTH{1'b0}}, mag(a)};
                mplier_d = mag(opb);
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = MUL_RUN;
              end
              default: begin
                if (opb == '0) begin
                  result_d = '0;
                  ovf_d    = 1'b0;
                  dbz_d    = 1'b1;
                  done_d   = 1'b1;
                end else begin
                  neg_d    = a[WIDTH-1] ^ opb[WIDTH-1];
                  mcand_d  = {{WIDTH{1'b0}}, mag(opb)};
                  mplier_d = mag(a);
                  rem_d    = '0;
                  quo_d    = '0;
                  cnt_d    = '0;
                  state_d  = DIV_RUN;
                end
              end
            endcase
          end
        end
        MUL_RUN: begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 6'd1;
          if (cnt_q == CNT_LAST) begin
            mag_x   = {1'b0, acc_step};
            exact_x = neg_q ? -mag_x : mag_x;
            fin     = 1'b1;
            state_d = IDLE;
          end
        end
        DIV_RUN: begin
          rem_d    = rem_ge ? (rem_sh[WIDTH-1:0] - mcand_q[WIDTH-1:0]) : rem_sh[WIDTH-1:0];
          quo_d    = quo_step;
          mplier_d = mplier_q << 1;
          cnt_d    = cnt_q + 6'd1;
          if (cnt_q == CNT_LAST) begin
            mag_x   = {{(WIDTH+1){1'b0}}, quo_step};
            exact_x = neg_q ? -mag_x : mag_x;
            fin     = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (fin) begin
        fin_x    = finalize(exact_x);
        result_d = fin_x[WIDTH-1:0];
        ovf_d    = fin_x[WIDTH];
        dbz_d    = 1'b0;
        done_d   = 1'b1;
      end
    end
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

  assign result      = result_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_seq_calc_core.sv
// Directed bench for seq_calc_core: a wrapping and a saturating instance share
// the same stimulus; expected values are hand-computed for WIDTH=8.
module tb_seq_calc_core;

  logic       clk = 1'b0;
  logic       reset, enable, start, chain;
  logic [2:0] op;
  logic [7:0] a, b;
  logic [7:0] res_w, res_s;
  logic       ovf_w, ovf_s, dbz_w, dbz_s, busy_w, busy_s, done_w, done_s;

  int total = 0;
  int bad   = 0;

  seq_calc_core #(.WIDTH(8), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .op(op), .chain(chain),
    .a(a), .b(b), .result(res_w), .overflow(ovf_w), .div_by_zero(dbz_w),
    .busy(busy_w), .done(done_w)
  );

  seq_calc_core #(.WIDTH(8), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .op(op), .chain(chain),
    .a(a), .b(b), .result(res_s), .overflow(ovf_s), .div_by_zero(dbz_s),
    .busy(busy_s), .done(done_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait (bounded) for its done pulse.
  task automatic run(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                     input logic ch, output int edges, output int busy_n);
    op = o; a = av; b = bv; chain = ch; start = 1'b1;
    tick;
    start = 1'b0;
    edges = 1;
    busy_n = 0;
    while (!done_w && edges < 40) begin
      if (busy_w) busy_n++;
      tick;
      edges++;
    end
  endtask

  task automatic check_op(input string tag, input logic [2:0] o, input logic [7:0] av,
                          input logic [7:0] bv, input logic ch, input int exp_edges,
                          input logic [7:0] exp_rw, input logic [7:0] exp_rs,
                          input logic exp_ovf, input logic exp_dbz);
    int edges, busy_n;
    run(o, av, bv, ch, edges, busy_n);
    $display("op %s: op=%0d a=%0h b=%0h chain=%0b edges=%0d res_w=%0h res_s=%0h ovf=%0b dbz=%0b",
             tag, o, av, bv, ch, edges, res_w, res_s, ovf_w, dbz_w);
    check({tag, ".edges"}, edges, exp_edges);
    check({tag, ".busy_edges"}, busy_n, exp_edges - 1);
    check({tag, ".busy_at_done"}, {busy_w, busy_s}, 2'b00);
    check({tag, ".res_w"}, res_w, exp_rw);
    check({tag, ".res_s"}, res_s, exp_rs);
    check({tag, ".ovf"}, {ovf_w, ovf_s}, {exp_ovf, exp_ovf});
    check({tag, ".dbz"}, {dbz_w, dbz_s}, {exp_dbz, exp_dbz});
    tick;
    check({tag, ".done_clear"}, {done_w, done_s}, 2'b00);
    check({tag, ".res_hold"}, res_w, exp_rw);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, done_seen;
    reset = 1'b1; enable = 1'b1; start = 1'b0; chain = 1'b0; op = 3'd0; a = '0; b = '0;
    #1;
    check("reset.outs", {res_w, ovf_w, dbz_w, busy_w, done_w}, 12'h000);
    check("reset.outs_s", {res_s, ovf_s, dbz_s, busy_s, done_s}, 12'h000);
    repeat (2) tick;
    reset = 1'b0;

    check_op("chain0_add", 3'd0, 8'h05, 8'h63, 1'b1, 1, 8'h05, 8'h05, 1'b0, 1'b0);
    check_op("add",        3'd0, 8'h04, 8'h09, 1'b0, 1, 8'h0D, 8'h0D, 1'b0, 1'b0);
    check_op("sub",        3'd1, 8'h04, 8'h09, 1'b0, 1, 8'hFB, 8'hFB, 1'b0, 1'b0);
    check_op("mul",        3'd6, 8'h04, 8'h09, 1'b0, 9, 8'h24, 8'h24, 1'b0, 1'b0);
    check_op("mul_ovf",    3'd6, 8'hF4, 8'h0B, 1'b0, 9, 8'h7C, 8'h80, 1'b1, 1'b0);
    check_op("add_ovf",    3'd0, 8'h64, 8'h64, 1'b0, 1, 8'hC8, 8'h7F, 1'b1, 1'b0);
    check_op("div",        3'd7, 8'hF9, 8'h02, 1'b0, 9, 8'hFD, 8'hFD, 1'b0, 1'b0);
    check_op("div0",       3'd7, 8'h05, 8'h00, 1'b0, 1, 8'h00, 8'h00, 1'b0, 1'b1);
    check_op("div_ovf",    3'd7, 8'h80, 8'hFF, 1'b0, 9, 8'h80, 8'h7F, 1'b1, 1'b0);
    check_op("neg_min",    3'd5, 8'h80, 8'h00, 1'b0, 1, 8'h80, 8'h7F, 1'b1, 1'b0);
    check_op("xor",        3'd4, 8'hF0, 8'h3C, 1'b0, 1, 8'hCC, 8'hCC, 1'b0, 1'b0);
    check_op("and",        3'd2, 8'hF0, 8'h3C, 1'b0, 1, 8'h30, 8'h30, 1'b0, 1'b0);
    check_op("or",         3'd3, 8'hF0, 8'h3C, 1'b0, 1, 8'hFC, 8'hFC, 1'b0, 1'b0);
    check_op("add_pre",    3'd0, 8'h04, 8'h09, 1'b0, 1, 8'h0D, 8'h0D, 1'b0, 1'b0);
    check_op("chain_mul",  3'd6, 8'h02, 8'h55, 1'b1, 9, 8'h1A, 8'h1A, 1'b0, 1'b0);
    check_op("mul_negneg", 3'd6, 8'hFB, 8'hFB, 1'b0, 9, 8'h19, 8'h19, 1'b0, 1'b0);

    // start held high while busy must be ignored
    op = 3'd6; a = 8'h03; b = 8'h07; chain = 1'b0; start = 1'b1;
    tick;
    op = 3'd0; a = 8'h01; b = 8'h01;
    tick; tick;
    start = 1'b0;
    edges = 3;
    while (!done_w && edges < 40) begin tick; edges++; end
    $display("op busy_start: mul 3*7 edges=%0d res=%0h", edges, res_w);
    check("busy_start.edges", edges, 9);
    check("busy_start.res", res_w, 8'h15);
    tick;

    // enable low for 5 cycles in the middle of a MUL
    op = 3'd6; a = 8'h03; b = 8'h05; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    edges = 3;
    enable = 1'b0;
    repeat (5) tick;
    edges += 5;
    check("freeze.busy_done", {busy_w, done_w}, 2'b10);
    check("freeze.res", res_w, 8'h15);
    enable = 1'b1;
    while (!done_w && edges < 60) begin tick; edges++; end
    $display("op freeze: mul 3*5 edges=%0d res=%0h", edges, res_w);
    check("freeze.edges", edges, 14);
    check("freeze.res_done", res_w, 8'h0F);
    enable = 1'b0;
    tick; tick;
    check("freeze.done_ext", done_w, 1'b1);
    enable = 1'b1;
    tick;
    check("freeze.done_end", done_w, 1'b0);

    // reset three edges into a MUL aborts it
    op = 3'd6; a = 8'h04; b = 8'h09; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    #2 reset = 1'b1;
    #1;
    $display("op reset_abort: res_w=%0h busy=%0b done=%0b", res_w, busy_w, done_w);
    check("abort.outs", {res_w, ovf_w, dbz_w, busy_w, done_w}, 12'h000);
    check("abort.outs_s", {res_s, busy_s, done_s}, 10'h000);
    tick;
    reset = 1'b0;
    done_seen = 0;
    repeat (12) begin tick; if (done_w) done_seen++; end
    check("abort.no_done", done_seen, 0);
    check_op("add_after_reset", 3'd0, 8'h04, 8'h09, 1'b0, 1, 8'h0D, 8'h0D, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_calc_core.md
SEQ_CALC_CORE -- requirements
Module: seq_calc_core

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (signed two's complement), legal range 4..32.
REQ-002 Parameter SATURATE, default 0; 0 wraps overflowed results, 1 clamps them.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  1 = run; 0 = freeze all internal state and outputs.
REQ-006 start  input  1  request an operation; sampled only when idle and enable=1.
REQ-007 op  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NEG(-A), 6 MUL, 7 DIV.
REQ-008 chain  input  1  1 = operand B taken from current result register instead of b.
REQ-009 a  input  WIDTH  signed operand A.
REQ-010 b  input  WIDTH  signed operand B.
REQ-011 result  output  WIDTH  signed registered result.
REQ-012 overflow  output  1  last completed result overflowed (wrapped or clamped).
REQ-013 div_by_zero  output  1  last completed operation was DIV with B=0.
REQ-014 busy  output  1  operation in progress.
REQ-015 done  output  1  one-cycle completion pulse.

Function
REQ-016 States: IDLE, MUL_RUN, DIV_RUN, FINISH; reset state IDLE.
REQ-017 Accept: edge with state IDLE, enable=1, start=1 latches op, A=a, B=(chain ? result : b).
REQ-018 ADD/SUB/AND/OR/XOR/NEG: result, flags and done=1 registered on the accepting edge (latency 1 edge); state stays IDLE, busy stays 0.
REQ-019 MUL: accepting edge enters MUL_RUN, busy=1; shift-add on magnitudes, one bit per edge, WIDTH edges; sign applied at end; done pulse registered on edge WIDTH+1 counted from accept (inclusive), state back to IDLE same edge.
REQ-020 DIV: restoring division on magnitudes, one quotient bit per edge, same timing as MUL; quotient truncated toward zero; remainder discarded.
REQ-021 DIV with B=0: completes on accepting edge, result=0, div_by_zero=1, overflow=0, no DIV_RUN.
REQ-022 Overflow: ADD/SUB signed overflow; NEG of MIN; MUL when full 2*WIDTH product not representable in WIDTH; DIV of MIN by -1; logic ops never overflow.
REQ-023 SATURATE=0: overflowed result = low WIDTH bits of exact result; SATURATE=1: result = MAX (2^(WIDTH-1)-1) or MIN (-2^(WIDTH-1)) by sign of exact result.
REQ-024 result, overflow, div_by_zero hold until next completion; done high exactly one enabled edge per completion.
REQ-025 start while busy=1 ignored, no queuing; start held high in IDLE re-accepts every enabled edge.
REQ-026 enable=0: no state, counter, result, flag or done change; done pulse in progress extends until next enabled edge.
REQ-027 chain=1 with result never written uses B=0.

Reset
REQ-028 reset=1 forces immediately, independent of clk: state IDLE, result=0, overflow=0, div_by_zero=0, busy=0, done=0, counter and datapath registers 0.
REQ-029 reset during MUL_RUN/DIV_RUN aborts; no done pulse for aborted operation.
REQ-030 First start accepted on first rising edge after reset deasserts.

Verification (WIDTH=8)
REQ-031 ADD a=4 b=9 -> result=13, done one edge after accept, busy never 1; SUB -> -5.
REQ-032 MUL a=4 b=9 -> busy 1 for 8 edges, done on edge 9, result=36; MUL -12*11 -> 124, overflow=1 (SATURATE=0) / -128 (SATURATE=1).
REQ-033 ADD 100+100 -> -56, overflow=1 (SATURATE=0); 127 (SATURATE=1).
REQ-034 DIV -7/2 -> -3; DIV 5/0 -> result 0, div_by_zero=1, done after 1 edge; DIV -128/-1 -> overflow=1.
REQ-035 ADD 4+9 then chain=1 MUL a=2 -> 26; enable=0 for 5 cycles mid-MUL -> done delayed exactly 5 cycles, result unchanged.
REQ-036 reset asserted 3 edges into MUL -> all outputs 0 immediately, no done; new ADD after release completes normally.
